// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state type and lane-merge helper for the load/store unit
//
// Purpose: funct3 codes, dmem lane encodings and the controller state enum
// used by lsu_ctrl and lsu_decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Full-word read (no sign extension) and full-word write lane codes.
  localparam logic [4:0] RMEM_W = 5'b01111;
  localparam logic [3:0] WMEM_W = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_t;

  // Replace the selected byte lanes of old_word with the same lanes of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lanes[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lsu_decode.sv
// rtl/lsu_decode.sv - combinational request classifier for the load/store unit
//
// Purpose: from funct3, byte offset, direction and the upper address bits,
// decide whether the request is illegal and produce the dmem read code and
// the byte-lane mask the access touches.
// Ports:
//   funct3    in  3               RV32I funct3 of the request
//   offset    in  2               byte address [1:0]
//   we        in  1               1 = store
//   addr_hi   in  30-ADDR_WIDTH   byte address bits above the implemented range
//   err       out 1               misaligned, out of range or illegal funct3
//   rmem_code out 5               {sign_extend, lane_mask} for loads
//   lane_mask out 4               lanes touched by the access
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic [2:0]              funct3,
  input  logic [1:0]              offset,
  input  logic                    we,
  input  logic [29-ADDR_WIDTH:0]  addr_hi,
  output logic                    err,
  output logic [4:0]              rmem_code,
  output logic [3:0]              lane_mask
);

  logic sign_ext;

  always_comb begin
    err       = |addr_hi;
    lane_mask = 4'b0000;
    sign_ext  = 1'b0;
    case (funct3)
      F3_B: begin
        lane_mask = 4'b0001 << offset;
        sign_ext  = ~we;
      end
      F3_BU: begin
        lane_mask = 4'b0001 << offset;
        err       = err | we;
      end
      F3_H: begin
        lane_mask = offset[1] ? 4'b1100 : 4'b0011;
        sign_ext  = ~we;
        err       = err | offset[0];
      end
      F3_HU: begin
        lane_mask = offset[1] ? 4'b1100 : 4'b0011;
        err       = err | offset[0] | we;
      end
      F3_W: begin
        lane_mask = 4'b1111;
        err       = err | (offset != 2'b00);
      end
      default: err = 1'b1;
    endcase
    rmem_code = {sign_ext, lane_mask};
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store unit driving the dmem port
//
// Purpose: accepts one load/store per req handshake, drives dmem lane codes
// and word address, performs read-modify-write for sub-word stores (dmem
// zeroes unselected lanes), and returns the result over a resp handshake.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,
//   req_wdata                       request fields
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_err            extended load data / error flag
//   wmem, rmem, mem_addr,
//   store_data                      dmem drive (dmem samples on negedge)
//   load_data                       dmem read result, already lane-extracted
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data
);

  lsu_state_t state, state_nxt;

  logic        dec_err;
  logic [4:0]  dec_rmem;
  logic [3:0]  dec_lanes;
  logic        accept;

  logic [31:0] mem_addr_q;
  logic [1:0]  offset_q;
  logic [4:0]  rmem_q;
  logic [3:0]  lanes_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic        err_q;

  assign accept = (state == IDLE) && req_valid;

  lsu_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_decode (
    .funct3    (req_funct3),
    .offset    (req_addr[1:0]),
    .we        (req_we),
    .addr_hi   (req_addr[31:ADDR_WIDTH+2]),
    .err       (dec_err),
    .rmem_code (dec_rmem),
    .lane_mask (dec_lanes)
  );

  // State register. wmem is decoded from state, so the async reset pulls it
  // low immediately and an interrupted write never reaches dmem.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (dec_err)                    state_nxt = RESP;
          else if (!req_we)               state_nxt = LOAD;
          else if (req_funct3 == F3_W)    state_nxt = STORE;
          else                            state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      STORE:   state_nxt = RESP;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    wmem       = 4'b0000;
    rmem       = 5'b00000;
    store_data = 32'h0;
    case (state)
      LOAD:   rmem = rmem_q;
      RMW_RD: rmem = RMEM_W;
      STORE, RMW_WR: begin
        wmem       = WMEM_W;
        store_data = data_q;
      end
      default: ;
    endcase
  end

  assign mem_addr   = mem_addr_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Request latch and data capture. data_q holds the store word; for a
  // sub-word store it is overwritten by the merged word during RMW_RD so
  // RMW_WR only has to present it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= 32'h0;
      offset_q   <= 2'b00;
      rmem_q     <= 5'b00000;
      lanes_q    <= 4'b0000;
      data_q     <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr_q <= {2'b00, req_addr[31:2]};
        offset_q   <= req_addr[1:0];
        rmem_q     <= dec_rmem;
        lanes_q    <= dec_lanes;
        data_q     <= req_wdata;
        rdata_q    <= 32'h0;
        err_q      <= dec_err;
      end else if (state == LOAD) begin
        rdata_q <= load_data;
      end else if (state == RMW_RD) begin
        data_q <= merge_lanes(load_data, data_q << {offset_q, 3'b000}, lanes_q);
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a dmem model and request-level reference model
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_WIDTH(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .wmem       (wmem),
    .rmem       (rmem),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .load_data  (load_data)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // dmem model: lane-extracting, extending read; negedge write that zeroes
  // unselected lanes.
  logic [31:0] dmem    [0:32767];
  logic [31:0] exp_mem [0:32767];

  function automatic logic [31:0] dmem_read(input logic [4:0] code, input logic [31:0] w);
    logic [31:0] v;
    int lo;
    int n;
    lo = 0;
    n  = 0;
    for (int i = 3; i >= 0; i--) if (code[i]) lo = i;
    for (int i = 0; i < 4; i++) if (code[i]) n++;
    v = w >> (8 * lo);
    if (n == 0)      v = 32'h0;
    else if (n == 1) v = code[4] ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
    else if (n == 2) v = code[4] ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
    return v;
  endfunction

  assign load_data = dmem_read(rmem, dmem[mem_addr[14:0]]);

  always @(negedge clk) begin
    if (wmem != 4'b0000)
      dmem[mem_addr[14:0]] <= store_data & {{8{wmem[3]}}, {8{wmem[2]}}, {8{wmem[1]}}, {8{wmem[0]}}};
  end

  // Reference model: one request in flight, classified at acceptance.
  // cls: 0 error, 1 load, 2 word store, 3 sub-word store.
  bit          busy = 1'b0;
  int          cyc = 0;
  int          acc = 0;
  int          cls = 0;
  int          lat = 0;
  int          tk;
  logic [14:0] m_word;
  logic [31:0] m_maddr, m_rdata, m_wdata, m_merged, m_w, m_sh, m_ld, m_mask;
  logic [4:0]  m_rmem;
  logic [3:0]  m_lanes;
  logic [1:0]  m_off, m_sz;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        tk = cyc - acc;
        if (cls == 2 && tk == 1) exp_mem[m_word] = m_wdata;
        if (cls == 3 && tk == 2) exp_mem[m_word] = m_merged;
        if (tk >= lat && resp_ready) busy = 1'b0;
      end else if (req_valid) begin
        m_off   = req_addr[1:0];
        m_sz    = req_funct3[1:0];
        m_err   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_we && req_funct3[2]) || (req_addr >= 32'h0002_0000) ||
                  (m_sz == 2'd2 && m_off != 2'd0) || (m_sz == 2'd1 && m_off[0]);
        m_word  = req_addr[16:2];
        m_maddr = req_addr >> 2;
        m_w     = exp_mem[m_word];
        m_lanes = (m_sz == 2'd0) ? (4'b0001 << m_off) : (m_sz == 2'd1) ? (4'b0011 << m_off) : 4'b1111;
        m_rmem  = {(!req_funct3[2] && m_sz != 2'd2), m_lanes};
        m_sh    = m_w >> (8 * m_off);
        case (req_funct3)
          3'b000:  m_ld = {{24{m_sh[7]}}, m_sh[7:0]};
          3'b100:  m_ld = {24'h0, m_sh[7:0]};
          3'b001:  m_ld = {{16{m_sh[15]}}, m_sh[15:0]};
          3'b101:  m_ld = {16'h0, m_sh[15:0]};
          default: m_ld = m_w;
        endcase
        m_mask   = ((m_sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * m_off);
        m_merged = (m_w & ~m_mask) | ((req_wdata << (8 * m_off)) & m_mask);
        m_wdata  = req_wdata;
        m_rdata  = 32'h0;
        if (m_err)                 begin cls = 0; lat = 1; end
        else if (!req_we)          begin cls = 1; lat = 2; m_rdata = m_ld; end
        else if (m_sz == 2'd2)     begin cls = 2; lat = 2; end
        else                       begin cls = 3; lat = 3; end
        busy = 1'b1;
        acc  = cyc;
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model.
  int ck;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err", 32'(resp_err), 32'h0);
      chk("rst_wmem", 32'(wmem), 32'h0);
      chk("rst_rmem", 32'(rmem), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_store_data", store_data, 32'h0);
    end else if (!busy) begin
      chk("idle_req_ready", 32'(req_ready), 32'h1);
      chk("idle_resp_valid", 32'(resp_valid), 32'h0);
      chk("idle_wmem", 32'(wmem), 32'h0);
      chk("idle_rmem", 32'(rmem), 32'h0);
    end else begin
      ck = cyc - acc;
      chk("busy_req_ready", 32'(req_ready), 32'h0);
      if (ck >= lat) begin
        chk("resp_valid", 32'(resp_valid), 32'h1);
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("resp_wmem", 32'(wmem), 32'h0);
        chk("resp_rmem", 32'(rmem), 32'h0);
      end else begin
        chk("acc_resp_valid", 32'(resp_valid), 32'h0);
        chk("acc_mem_addr", mem_addr, m_maddr);
        if (cls == 1) begin
          chk("load_rmem", 32'(rmem), 32'(m_rmem));
          chk("load_wmem", 32'(wmem), 32'h0);
        end else if (cls == 2) begin
          chk("sw_wmem", 32'(wmem), 32'hF);
          chk("sw_rmem", 32'(rmem), 32'h0);
          chk("sw_store_data", store_data, m_wdata);
        end else if (ck == 1) begin
          chk("rmw_rd_rmem", 32'(rmem), 32'h0F);
          chk("rmw_rd_wmem", 32'(wmem), 32'h0);
        end else begin
          chk("rmw_wr_wmem", 32'(wmem), 32'hF);
          chk("rmw_wr_rmem", 32'(rmem), 32'h0);
          chk("rmw_wr_store_data", store_data, m_merged);
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [4:0] rmem1, output logic [31:0] maddr1,
                        output logic [3:0] wmem2, output logic [31:0] sdata2,
                        output int rn, output logic [31:0] rdata, output logic rerr);
    rmem1 = 5'h0; maddr1 = 32'h0; wmem2 = 4'h0; sdata2 = 32'h0;
    rn = 0; rdata = 32'h0; rerr = 1'b0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin rmem1 = rmem; maddr1 = mem_addr; end
      if (n == 2) begin wmem2 = wmem; sdata2 = store_data; end
      if (resp_valid) begin
        rn = n; rdata = resp_rdata; rerr = resp_err;
        break;
      end
    end
    if (rn == 0) chk("resp_timeout", 32'h0, 32'h1);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_req_ready", 32'(req_ready), 32'h0);
        chk("hold_rdata", resp_rdata, rdata);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  r1;
  logic [31:0] a1, s2, rd;
  logic [3:0]  w2;
  logic        re;
  int          rn;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      dmem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    dmem[32'h40] = 32'hDEADBEEF;
    exp_mem[32'h40] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);

    do_req(1'b0, 3'b000, 32'h103, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("lb_rmem", 32'(r1), 32'h18);
    chk("lb_mem_addr", a1, 32'h40);
    chk("lb_latency", 32'(rn), 32'd2);
    chk("lb_rdata", rd, 32'hFFFFFFDE);
    chk("lb_err", 32'(re), 32'h0);

    do_req(1'b0, 3'b101, 32'h102, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("lhu_rmem", 32'(r1), 32'h0C);
    chk("lhu_rdata", rd, 32'h0000DEAD);
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("lh_rmem", 32'(r1), 32'h1C);
    chk("lh_rdata", rd, 32'hFFFFDEAD);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("lw_rmem", 32'(r1), 32'h0F);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    do_req(1'b1, 3'b000, 32'h101, 32'h12345655, 0, r1, a1, w2, s2, rn, rd, re);
    chk("sb_rmem", 32'(r1), 32'h0F);
    chk("sb_wmem", 32'(w2), 32'hF);
    chk("sb_store_data", s2, 32'hDEAD55EF);
    chk("sb_latency", 32'(rn), 32'd3);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("lw_after_sb", rd, 32'hDEAD55EF);

    // Error cases: response in cycle 1, no memory activity.
    do_req(1'b0, 3'b010, 32'h102, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("err_lw_mis", {rn[7:0], 7'h0, re, rd[15:0]}, 32'h0101_0000);
    do_req(1'b1, 3'b001, 32'h101, 32'hFFFF, 0, r1, a1, w2, s2, rn, rd, re);
    chk("err_sh_mis", {rn[7:0], 7'h0, re, rd[15:0]}, 32'h0101_0000);
    chk("err_sh_rmem", 32'(r1), 32'h0);
    do_req(1'b0, 3'b000, 32'h0002_0000, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("err_lb_range", {rn[7:0], 7'h0, re, rd[15:0]}, 32'h0101_0000);
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("err_f3_011", {rn[7:0], 7'h0, re, rd[15:0]}, 32'h0101_0000);
    do_req(1'b1, 3'b100, 32'h100, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("err_store_f3_100", 32'(re), 32'h1);

    // Word store, sub-word store and loads at another word; top-of-range load.
    do_req(1'b1, 3'b010, 32'h200, 32'h11223344, 0, r1, a1, w2, s2, rn, rd, re);
    chk("sw_latency", 32'(rn), 32'd2);
    do_req(1'b0, 3'b100, 32'h201, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("lbu_rdata", rd, 32'h00000033);
    do_req(1'b1, 3'b001, 32'h202, 32'hFFFF8001, 0, r1, a1, w2, s2, rn, rd, re);
    chk("sh_store_data", s2, 32'h80013344);
    do_req(1'b0, 3'b001, 32'h202, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("lh_neg_rdata", rd, 32'hFFFF8001);
    do_req(1'b0, 3'b010, 32'h0001_FFFC, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("lw_top_err", 32'(re), 32'h0);
    chk("lw_top_mem_addr", a1, 32'h7FFF);

    // Backpressure on the response, then immediate next request.
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 5, r1, a1, w2, s2, rn, rd, re);
    chk("hold_rdata_val", rd, 32'hDEAD55EF);
    chk("hold_release_ready", 32'(req_ready), 32'h1);
    do_req(1'b0, 3'b100, 32'h100, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("after_hold_latency", 32'(rn), 32'd2);
    chk("after_hold_rdata", rd, 32'h000000EF);

    // Reset asserted during RMW_WR.
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h101; req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 chk("pre_rst_wmem", 32'(wmem), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wmem", 32'(wmem), 32'h0);
    chk("async_rst_store_data", store_data, 32'h0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk("async_rst_resp_valid", 32'(resp_valid), 32'h0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);
    chk("post_rst_mem_word", dmem[32'h40], 32'hDEAD55EF);
    chk("post_rst_model_word", dmem[32'h40], exp_mem[32'h40]);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 0, r1, a1, w2, s2, rn, rd, re);
    chk("post_rst_lw", rd, 32'hDEAD55EF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit on the CPU side of the data-memory port. It is the initiator that drives dmem's wmem/rmem/mem_addr/store_data and consumes load_data.
- Accepts one RV32I load/store per valid/ready handshake from the execute stage. It encodes lane masks, converts byte addresses to word addresses, checks alignment and range, and returns the result over a valid/ready response.
- dmem writes zeros into unselected byte lanes, so byte/halfword stores run as read-modify-write with full-word writes.

Parameters:
- ADDR_WIDTH, 15, word-address bits implemented by dmem. Byte addresses at or above 2**(ADDR_WIDTH+2) are out of range.

Ports:
- clk  in  1  system clock; dmem samples on negedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result, already extended; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3; no memory access performed.
- wmem  out  4  dmem write lane mask; this block only drives 0000 or 1111.
- rmem  out  5  dmem load encoding: bit4 = sign-extend, [3:0] = lane mask.
- mem_addr  out  32  word address = req_addr>>2, zero-extended.
- store_data  out  32  dmem write data.
- load_data  in  32  dmem read result; valid by end of the cycle in which rmem/mem_addr are driven.

Behaviour:
- All outputs are registered or decoded from state only; none are combinational from req_*.
- Reset: state=IDLE. resp_valid=0, resp_rdata=0, resp_err=0, wmem=0, rmem=0, mem_addr=0, store_data=0. req_ready=1 once rst_n is released.
- Reset mid-operation: wmem drops to 0 asynchronously, so no partial write reaches dmem. Any in-flight request is discarded.
- Request latch: in IDLE, req_valid=1 latches addr, funct3, we and wdata, with offset = addr[1:0].
- Error check:
  - Size 2 with offset!=0 is an error.
  - Size 1 with offset[0]!=0 is an error.
  - Any of addr[31:ADDR_WIDTH+2] set is an error.
  - funct3 in {011,110,111} is an error; for stores, {100,101} are also errors.
  - Error -> RESP with resp_err=1, with no wmem/rmem activity.
- State sequence, with the acceptance cycle numbered 0:
  - IDLE -> LOAD: cycle 1, rmem=encoding. load_data is captured at the end of cycle 1, then RESP from cycle 2.
  - IDLE -> STORE: word store. Cycle 1, wmem=1111, store_data=wdata. RESP from cycle 2.
  - IDLE -> RMW_RD -> RMW_WR: byte/halfword store.
    - RMW_RD (cycle 1): rmem=01111, old word captured.
    - RMW_WR (cycle 2): wmem=1111, store_data = old word with the target lanes replaced by wdata[7:0] or wdata[15:0].
    - RESP from cycle 3.
  - Error: RESP from cycle 1.
- RESP: resp_valid=1, with rdata/err held stable. If resp_ready=1, go to IDLE next cycle; otherwise stay. A new request is accepted only after returning to IDLE (no bypass).
- rmem encoding:
  - LW = 01111.
  - LB/LBU: lane = 1<<offset, bit4 = 1 for LB.
  - LH/LHU: offset 0 -> 0011, offset 2 -> 1100, bit4 = 1 for LH.
- In all states other than LOAD/RMW_RD/STORE/RMW_WR: rmem=0, wmem=0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - rmem/wmem encoding constants (RMEM_W=5'b01111, WMEM_W=4'b1111).
  - state enum lsu_state_t {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP}.
- One sub-module, lsu_decode: a combinational function of funct3/offset/we/addr. It produces the error flag, the rmem code and the RMW merge lane mask.

Test Plan:
- Preload word index 0x40 (byte 0x100) = 0xDEADBEEF. LB addr 0x103 -> rmem=11000, mem_addr=0x40 in cycle 1, resp_valid cycle 2, resp_rdata=0xFFFFFFDE, err=0.
- LHU 0x102 -> rmem=01100, rdata=0x0000DEAD. LH 0x102 -> rmem=11100, rdata=0xFFFFDEAD. LW 0x100 -> rmem=01111, rdata=0xDEADBEEF.
- SB 0x101, wdata=0x12345655 -> cycle 1 rmem=01111, cycle 2 wmem=1111 with store_data=0xDEAD55EF, resp cycle 3. A subsequent LW 0x100 returns 0xDEAD55EF.
- LW 0x102, SH 0x101, LB 0x0002_0000 and funct3=011 -> each gives resp_err=1 in cycle 1, rdata=0, wmem/rmem stay 0 throughout.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid/rdata stable and req_ready=0. Release -> IDLE next cycle, next request accepted.
- Assert rst_n=0 mid-cycle during RMW_WR -> wmem=0 immediately, memory word unchanged, all outputs at reset values, req_ready=1 after release.
